// File: rtl/seq_arith_unit.sv
// Sequential signed/unsigned multiplier and restoring divider sharing one shift/add-subtract datapath.
// The divider is compiled in only when SEQ_ARITH_DIV_EN is defined; otherwise div ops return 0 with err set.
module seq_arith_unit #(
  parameter int unsigned WORD_LENGTH = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [WORD_LENGTH-1:0]     a,
  input  logic [WORD_LENGTH-1:0]     b,
  output logic                       ready,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   result,
  output logic                       err
);

  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned RW = 2 * WORD_LENGTH;
  localparam int unsigned CW = $clog2(WORD_LENGTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      op_q;
  logic [W-1:0]    a_raw, b_raw;
  logic [W-1:0]    opa, opb;
  logic [RW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg_res;
  logic            is_div, is_signed;
  logic [W:0]      mult_sum;
  logic [RW-1:0]   mult_acc;
  logic [RW-1:0]   prod_fix;
  logic [RW-1:0]   res_fix;
  logic            err_fix;
`ifdef SEQ_ARITH_DIV_EN
  logic            neg_rem, div_zero;
  logic [W:0]      rem_sh;
  logic            trial_ok;
  logic [W-1:0]    rem_new;
  logic [RW-1:0]   div_acc;
  logic [W-1:0]    quo_fix, rem_fix;
`endif

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Magnitude of a two's-complement word; -2^(W-1) maps to unsigned 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? ~x + W'(1) : x;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt == CW'(W - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of shift-add (mult) or shift-trial-subtract (div), plus the sign fix-up.
  always_comb begin
    mult_sum = {1'b0, acc[RW-1:W]} + (opb[0] ? {1'b0, opa} : '0);
    mult_acc = {mult_sum, acc[W-1:1]};
    prod_fix = neg_res ? ~acc + RW'(1) : acc;
`ifdef SEQ_ARITH_DIV_EN
    rem_sh   = acc[RW-1:W-1];
    trial_ok = rem_sh >= {1'b0, opb};
    rem_new  = trial_ok ? rem_sh[W-1:0] - opb : rem_sh[W-1:0];
    div_acc  = {rem_new, acc[W-2:0], trial_ok};
    quo_fix  = div_zero ? '1 : (neg_res ? ~acc[W-1:0] + W'(1) : acc[W-1:0]);
    rem_fix  = div_zero ? a_raw : (neg_rem ? ~acc[RW-1:W] + W'(1) : acc[RW-1:W]);
    res_fix  = is_div ? {rem_fix, quo_fix} : prod_fix;
    err_fix  = is_div & div_zero;
`else
    res_fix  = is_div ? '0 : prod_fix;
    err_fix  = is_div;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_raw    <= '0;
      b_raw    <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
`ifdef SEQ_ARITH_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
`endif
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      done  <= (state == FIX);
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          a_raw <= a;
          b_raw <= b;
        end
        LOAD: begin
          opa     <= mag(a_raw, is_signed);
          opb     <= mag(b_raw, is_signed);
          neg_res <= is_signed & (a_raw[W-1] ^ b_raw[W-1]);
          cnt     <= '0;
`ifdef SEQ_ARITH_DIV_EN
          neg_rem  <= is_signed & a_raw[W-1];
          div_zero <= is_div & (b_raw == '0);
          acc      <= is_div ? {{W{1'b0}}, mag(a_raw, is_signed)} : '0;
`else
          acc      <= '0;
`endif
        end
        RUN: begin
          cnt <= cnt + CW'(1);
`ifdef SEQ_ARITH_DIV_EN
          if (is_div) begin
            acc <= div_acc;
          end else begin
            acc <= mult_acc;
            opb <= opb >> 1;
          end
`else
          acc <= mult_acc;
          opb <= opb >> 1;
`endif
        end
        FIX: begin
          result <= res_fix;
          err    <= err_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
